// File: rtl/lstm_layer_sequencer.sv
// Timestep/layer sequencer for the stacked LSTM datapath: takes one sample per timestep,
// fires each layer in turn, waits for its done, then hands off the final-layer result.
module lstm_layer_sequencer #(
  parameter int LAYERS     = 4,
  parameter int STEP_WIDTH = 16,
  parameter int TIMEOUT    = 1024,
  localparam int LAYER_W   = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [STEP_WIDTH-1:0] num_steps,
  input  logic                  abort,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  layer_start,
  output logic [LAYER_W-1:0]    layer_idx,
  output logic                  first_step,
  input  logic                  layer_done,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [STEP_WIDTH-1:0] step_count
);

  // state       | meaning
  // IDLE        | no sequence running; step_count/error hold last result
  // WAIT_SAMPLE | waiting for this timestep's input sample
  // ISSUE       | layer_start pulse for layer_idx, watchdog reloaded
  // WAIT_LAYER  | waiting for layer_done, watchdog counting down
  // ADVANCE     | one-cycle gap before the next layer is issued
  // EMIT        | result_valid held until result_ready
  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_WAIT_SAMPLE = 3'd1;
  localparam logic [2:0] S_ISSUE       = 3'd2;
  localparam logic [2:0] S_WAIT_LAYER  = 3'd3;
  localparam logic [2:0] S_ADVANCE     = 3'd4;
  localparam logic [2:0] S_EMIT        = 3'd5;

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0]   TMR_LOAD   = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(LAYERS - 1);

  logic [2:0]            state;
  logic [LAYER_W-1:0]    layer;
  logic [TMR_W-1:0]      timer;
  logic [STEP_WIDTH-1:0] steps_done;
  logic [STEP_WIDTH-1:0] num_lat;
  logic                  done_q;
  logic                  error_q;
  logic [STEP_WIDTH-1:0] steps_next;
  logic                  timeout_hit;

  assign steps_next  = steps_done + STEP_WIDTH'(1);
  // Watchdog fires on the cycle the down-counter is already at terminal count.
  assign timeout_hit = (TIMEOUT != 0) && (timer == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      layer      <= '0;
      timer      <= '0;
      steps_done <= '0;
      num_lat    <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state != S_IDLE && abort) begin
        state <= S_IDLE;
        layer <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              steps_done <= '0;
              error_q    <= 1'b0;
              if (num_steps == '0) begin
                done_q <= 1'b1;
              end else begin
                num_lat <= num_steps;
                state   <= S_WAIT_SAMPLE;
              end
            end
          end
          S_WAIT_SAMPLE: begin
            if (sample_valid) begin
              layer <= '0;
              state <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            timer <= TMR_LOAD;
            state <= S_WAIT_LAYER;
          end
          S_WAIT_LAYER: begin
            if (layer_done) begin
              if (layer == LAST_LAYER) begin
                state <= S_EMIT;
              end else begin
                layer <= layer + LAYER_W'(1);
                state <= S_ADVANCE;
              end
            end else if (timeout_hit) begin
              state   <= S_IDLE;
              layer   <= '0;
              error_q <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              timer <= timer - TMR_W'(1);
            end
          end
          S_ADVANCE: begin
            state <= S_ISSUE;
          end
          S_EMIT: begin
            if (result_ready) begin
              steps_done <= steps_next;
              if (steps_next == num_lat) begin
                state  <= S_IDLE;
                layer  <= '0;
                done_q <= 1'b1;
              end else begin
                state <= S_WAIT_SAMPLE;
              end
            end
          end
          default: begin
            state <= S_IDLE;
            layer <= '0;
          end
        endcase
      end
    end
  end

  // abort must kill the pulse/valid in the same cycle, not one later.
  assign layer_start  = (state == S_ISSUE) && !abort;
  assign result_valid = (state == S_EMIT) && !abort;
  assign sample_ready = (state == S_WAIT_SAMPLE);
  assign busy         = (state != S_IDLE);
  assign first_step   = busy && (steps_done == '0);
  assign layer_idx    = layer;
  assign done         = done_q;
  assign error        = error_q;
  assign step_count   = steps_done;

endmodule

// File: tb/tb_lstm_layer_sequencer.sv
// Bench for lstm_layer_sequencer: a per-cycle behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized sequences.
module tb_lstm_layer_sequencer;
  localparam int LAYERS = 4;
  localparam int SW     = 16;
  localparam int TO     = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [SW-1:0] num_steps;
  logic          abort;
  logic          sample_valid;
  logic          sample_ready;
  logic          layer_start;
  logic [1:0]    layer_idx;
  logic          first_step;
  logic          layer_done;
  logic          result_valid;
  logic          result_ready;
  logic          busy;
  logic          done;
  logic          error;
  logic [SW-1:0] step_count;

  always #5 clk = ~clk;

  lstm_layer_sequencer #(.LAYERS(LAYERS), .STEP_WIDTH(SW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .num_steps(num_steps), .abort(abort),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .layer_start(layer_start),
    .layer_idx(layer_idx), .first_step(first_step), .layer_done(layer_done),
    .result_valid(result_valid), .result_ready(result_ready), .busy(busy), .done(done),
    .error(error), .step_count(step_count)
  );

  int vec = 0;
  int mis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: where the sequence is, which layer, how long it has waited.
  localparam int P_IDLE = 0, P_SAMPLE = 1, P_FIRE = 2, P_WAIT = 3, P_GAP = 4, P_RESULT = 5;
  int          m_phase, m_layer, m_wait;
  logic [SW-1:0] m_t, m_n;
  bit          m_done, m_err;
  bit          m_valid = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", busy, m_phase != P_IDLE);
      chk("sample_ready", sample_ready, m_phase == P_SAMPLE);
      chk("layer_start", layer_start, m_phase == P_FIRE && !abort);
      chk("result_valid", result_valid, m_phase == P_RESULT && !abort);
      chk("done", done, m_done);
      chk("error", error, m_err);
      chk("step_count", step_count, m_t);
      if (m_phase == P_FIRE && !abort) begin
        chk("first_step", first_step, m_t == 0);
        chk("layer_idx", layer_idx, m_layer);
      end
      if (m_phase == P_IDLE) chk("layer_idx_idle", layer_idx, 0);
    end
    if (rst) begin
      m_phase = P_IDLE; m_layer = 0; m_wait = 0; m_t = 0; m_n = 0;
      m_done = 0; m_err = 0; m_valid = 1;
    end else if (m_valid) begin
      m_done = 0;
      if (m_phase != P_IDLE && abort) begin
        m_phase = P_IDLE; m_layer = 0;
      end else begin
        case (m_phase)
          P_IDLE: if (start) begin
            m_t = 0; m_err = 0;
            if (num_steps == 0) m_done = 1;
            else begin m_n = num_steps; m_phase = P_SAMPLE; end
          end
          P_SAMPLE: if (sample_valid) begin m_layer = 0; m_phase = P_FIRE; end
          P_FIRE: begin m_wait = 0; m_phase = P_WAIT; end
          P_WAIT: begin
            if (layer_done) begin
              if (m_layer == LAYERS - 1) m_phase = P_RESULT;
              else begin m_layer++; m_phase = P_GAP; end
            end else begin
              m_wait++;
              if (m_wait == TO) begin
                m_phase = P_IDLE; m_layer = 0; m_err = 1; m_done = 1;
              end
            end
          end
          P_GAP: m_phase = P_FIRE;
          P_RESULT: if (result_ready) begin
            m_t = m_t + 1;
            if (m_t == m_n) begin m_phase = P_IDLE; m_layer = 0; m_done = 1; end
            else m_phase = P_SAMPLE;
          end
          default: m_phase = P_IDLE;
        endcase
      end
    end
  end

  // Stimulus engine: layer responder, result consumer, sample source.
  int   cyc = 0, pend = 0, resp_delay = 5, hang_idx = -1, rr_hold = 0;
  bit   resp_rand = 0, rr_rand = 0, sv_rand = 0, sv_hold = 0;
  logic s_ls, s_rv, s_busy, s_done;
  logic [1:0] s_idx;
  int   n_ls, n_first, n_rv, n_hs, n_done, st_cyc, done_cyc;
  bit   busy_seen;
  int   idx_log[$];
  int   ls_cyc[$];

  task automatic tick();
    @(negedge clk);
    cyc++;
    s_ls = layer_start; s_rv = result_valid; s_busy = busy; s_done = done; s_idx = layer_idx;
    if (s_ls) begin
      n_ls++;
      if (first_step) n_first++;
      idx_log.push_back(int'(layer_idx));
      ls_cyc.push_back(cyc);
    end
    if (s_rv) n_rv++;
    if (s_rv && result_ready) n_hs++;
    if (s_done) begin n_done++; done_cyc = cyc; end
    if (s_busy) busy_seen = 1;
    @(posedge clk);
    #1;
    start = 0; abort = 0; layer_done = 0;
    if (s_ls && int'(s_idx) != hang_idx)
      pend = resp_rand ? $urandom_range(1, 6) : resp_delay;
    if (pend > 0) begin
      pend--;
      if (pend == 0) layer_done = 1;
    end
    if (rr_hold > 0) begin
      if (s_rv) rr_hold--;
      result_ready = (rr_hold == 0);
    end else begin
      result_ready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    sample_valid = sv_hold ? 1'b0 : (sv_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
  endtask

  task automatic clear_stats();
    n_ls = 0; n_first = 0; n_rv = 0; n_hs = 0; n_done = 0; busy_seen = 0;
    done_cyc = 0;
    idx_log.delete(); ls_cyc.delete();
  endtask

  task automatic begin_seq(input int n);
    start = 1; num_steps = SW'(n);
    tick();
    st_cyc = cyc;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k = 0;
    do begin tick(); k++; end while (s_busy && k < budget);
    chk(nm, s_busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1; start = 0; num_steps = 0; abort = 0; sample_valid = 0;
    layer_done = 0; result_ready = 1;
    clear_stats();
    repeat (3) tick();
    rst = 0;
    tick();

    // T1: three timesteps, fixed 5-cycle layer latency
    clear_stats();
    begin_seq(3);
    wait_idle(400, "t1_finish");
    chk("t1_layer_starts", n_ls, 12);
    chk("t1_first_steps", n_first, 4);
    chk("t1_results", n_hs, 3);
    chk("t1_done_count", n_done, 1);
    chk("t1_done_at_idle", s_done, 1);
    chk("t1_step_count", step_count, 3);
    if (n_ls == 12) begin
      for (int i = 0; i < 12; i++) chk("t1_idx_order", idx_log[i], i % 4);
      chk("t1_start_to_issue", ls_cyc[0] - st_cyc, 2);
      chk("t1_done_to_next_issue", ls_cyc[1] - ls_cyc[0], 7);
    end

    // T2: zero-length sequence
    clear_stats();
    begin_seq(0);
    tick();
    chk("t2_done_next", s_done, 1);
    tick();
    chk("t2_done_count", n_done, 1);
    chk("t2_busy_seen", busy_seen, 0);
    chk("t2_no_layer_start", n_ls, 0);

    // T3: result backpressure for 7 cycles
    clear_stats();
    result_ready = 0; rr_hold = 7;
    begin_seq(1);
    wait_idle(400, "t3_finish");
    chk("t3_valid_cycles", n_rv, 8);
    chk("t3_handshakes", n_hs, 1);
    chk("t3_step_count", step_count, 1);
    rr_hold = 0;

    // T4: layer 2 never answers
    clear_stats();
    hang_idx = 2;
    begin_seq(2);
    wait_idle(400, "t4_finish");
    chk("t4_error", error, 1);
    chk("t4_done_count", n_done, 1);
    chk("t4_layer_starts", n_ls, 3);
    if (n_ls == 3) chk("t4_timeout_latency", done_cyc - ls_cyc[2], 17);
    hang_idx = -1;
    begin_seq(1);
    tick();
    chk("t4_error_cleared", error, 0);
    wait_idle(400, "t4_rerun_finish");

    // T5: abort while waiting on layer 1 of timestep 1
    clear_stats();
    begin_seq(3);
    begin
      int k = 0;
      do begin tick(); k++; end
      while (!(s_ls && s_idx == 2'd1 && step_count == 1) && k < 400);
      chk("t5_reached_layer1", s_ls && s_idx == 2'd1, 1);
    end
    tick();
    abort = 1;
    tick();
    tick();
    chk("t5_idle_after_abort", s_busy, 0);
    repeat (5) tick();
    chk("t5_still_idle", busy, 0);
    chk("t5_step_count", step_count, 1);
    chk("t5_no_done", n_done, 0);
    chk("t5_error", error, 0);

    // T6: spurious layer_done and start while waiting for a sample
    clear_stats();
    sv_hold = 1;
    begin_seq(2);
    tick();
    layer_done = 1; start = 1; num_steps = 9;
    tick();
    tick();
    sv_hold = 0;
    wait_idle(400, "t6_finish");
    chk("t6_step_count", step_count, 2);
    chk("t6_layer_starts", n_ls, 8);
    chk("t6_results", n_hs, 2);
    chk("t6_done_count", n_done, 1);

    // Randomized sequences with stray aborts, starts, done pulses and occasional hangs
    resp_rand = 1; rr_rand = 1; sv_rand = 1;
    for (int s = 0; s < 30; s++) begin
      hang_idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
      begin_seq($urandom_range(1, 4));
      for (int k = 0; k < 600; k++) begin
        tick();
        if (!s_busy) break;
        if ($urandom_range(0, 149) == 0) abort = 1;
        if ($urandom_range(0, 39) == 0) begin start = 1; num_steps = SW'($urandom_range(0, 3)); end
        if ($urandom_range(0, 39) == 0) layer_done = 1;
      end
    end
    hang_idx = -1;

    // Reset in the middle of a sequence
    begin_seq(3);
    repeat (10) tick();
    rst = 1;
    tick();
    rst = 0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_step_count", step_count, 0);
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
